alu_ctrl_muldiv: RTL
====================

Name: alu_ctrl_muldiv

Overview:
Registered successor to the combinational ALU control decoder. It adds a parametrised datapath width and a conflict-free opcode map. It also adds an iterative shift-add multiplier that owns the HI/LO registers. The block sits between decode and execute. It issues a registered ALUOp per instruction, and stalls the front end while a mul/muli is in progress.

Parameters:
DATA_W, 16, operand width; product is 2*DATA_W split into HI/LO
CNT_W, $clog2(DATA_W)+1, multiplier iteration counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
valid_in  in  1  instruction present in decode this cycle
opcode  in  4  instruction opcode
funct  in  3  function field (R-type, MD-type, D-type)
src_a  in  DATA_W  multiplicand (rs value)
src_b  in  DATA_W  multiplier (rt value or extended immediate for muli)
alu_op  out  4  registered ALU operation code
alu_op_valid  out  1  alu_op corresponds to an accepted instruction this cycle
illegal  out  1  accepted instruction had an undefined opcode/funct
hilo_sel  out  2  00 none, 01 mfhi, 10 mflo (registered alongside alu_op)
stall  out  1  multiplier busy; upstream must hold the instruction
mul_done  out  1  one-cycle pulse; HI/LO hold the new product
hi  out  DATA_W  upper product half
lo  out  DATA_W  lower product half

Behaviour:
- Reset, synchronous and active-high, takes priority over all other logic. It clears alu_op=0000, alu_op_valid=0, illegal=0, hilo_sel=00, stall=0, mul_done=0, hi=0, lo=0, and sets state=IDLE. Reset asserted mid-multiply aborts the operation with no HI/LO update.
- Decode map (alu_op values):
  - opcode 0000, R-type: funct 000 add 0010, 001 and 0000, 010 sub 0110, 011 or 0001, 100 xor 1001, 101 nor 1010, 110 slt 0111, 111 jr 1111.
  - opcode 0001, MD-type: funct 000 mul 1000, 001 mfhi 1111 with hilo_sel=01, 010 mflo 1111 with hilo_sel=10.
  - opcodes 0010 addi 0010, 0011 andi 0000, 0100 ori 0001, 0101 muli 1000, 0110 beq 0110, 0111 bne 0110, 1000 slti 0111, 1001 lw 0010, 1010 sw 0010, 1011 j 1111, 1100 jal 1111.
  - opcode 1101, D-type: funct 000 sll 1100, 001 srl 0011, 010 sra 1101.
  - Any other opcode/funct: alu_op=0000, illegal=1, no side effects.
- Acceptance: valid_in is accepted when state is IDLE or DONE. Decode outputs register on that edge, so latency is 1 cycle. alu_op_valid=1 for the following cycle. When no instruction is accepted, alu_op_valid=0 and alu_op/hilo_sel/illegal hold their previous values.
- State machine IDLE -> MUL -> DONE:
  - IDLE: an accepted mul/muli latches src_a/src_b, clears the accumulator and counter, and moves to MUL.
  - MUL: stall=1. Each cycle: if multiplier LSB=1, add multiplicand to the accumulator upper half; shift right by one; increment the counter. When counter reaches DATA_W-1, write {hi,lo}=final product and move to DONE. Exactly DATA_W stall cycles.
  - DONE: stall=0, mul_done=1 for one cycle. An accepted mul/muli starts a new multiply (back-to-back), otherwise the state returns to IDLE.
- valid_in while stall=1 is ignored: no decode update, no restart. mfhi/mflo therefore always see the completed product.
- Default arithmetic is unsigned: a 2*DATA_W product with no overflow or truncation.
- HI/LO change only on multiply completion or reset.

Optional Feature:
MULDIV_SIGNED_EN: when defined, mul/muli treat operands as two's complement. The unit multiplies magnitudes, then negates the 2*DATA_W product when the operand signs differ. Latency is unchanged. When undefined, operands are unsigned.

Test Plan:
- Reset, then an R-type sweep (opcode 0000, funct 000..111), one per cycle -> alu_op 0010,0000,0110,0001,1001,1010,0111,1111, each one cycle after valid_in; alu_op_valid=1; illegal=0.
- mul src_a=0x1234, src_b=0x0010 -> stall high exactly 16 cycles, then mul_done pulse with hi=0x0001, lo=0x2340; a following mflo gives hilo_sel=10.
- mul 0xFFFF x 0xFFFF -> unsigned: hi=0xFFFE, lo=0x0001; with MULDIV_SIGNED_EN: hi=0x0000, lo=0x0001. Also 0xFFFF x 0x0002 signed -> hi=0xFFFF, lo=0xFFFE.
- valid_in with addi asserted during stall cycles 3..10 -> alu_op and alu_op_valid unchanged (0); hi/lo correct at completion.
- reset asserted in the 5th MUL cycle -> next cycle stall=0, hi=lo=0, mul_done never pulses.
- opcode 1110 and opcode 1101/funct 111 -> illegal=1, alu_op=0000, stall stays 0.

Source files
------------

// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv: registered ALU control decoder with an iterative
// shift-add multiplier that owns the HI/LO product registers.
// Optional build macro: MULDIV_SIGNED_EN (two's-complement mul/muli).
module alu_ctrl_muldiv #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [3:0]        opcode,
    input  logic [2:0]        funct,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic [3:0]        alu_op,
    output logic              alu_op_valid,
    output logic              illegal,
    output logic [1:0]        hilo_sel,
    output logic              stall,
    output logic              mul_done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [3:0]          alu_op_q, alu_op_d;
    logic                alu_op_valid_q, alu_op_valid_d;
    logic                illegal_q, illegal_d;
    logic [1:0]          hilo_sel_q, hilo_sel_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                neg_q, neg_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;

    logic [3:0]          dec_op;
    logic [1:0]          dec_hilo;
    logic                dec_ill;
    logic                dec_mul;
    logic                accept;

    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic                neg_in;
    logic [DATA_W:0]     upper_sum;
    logic [2*DATA_W-1:0] acc_step;
    logic [2*DATA_W-1:0] product;

    // The front end is only held off while the multiplier is iterating.
    assign accept = valid_in && (state_q != MUL);

    // Opcode/funct decode to ALU operation, HI/LO select and multiply flag.
    always_comb begin
        dec_op   = 4'b0000;
        dec_hilo = 2'b00;
        dec_ill  = 1'b0;
        dec_mul  = 1'b0;
        case (opcode)
            4'b0000: begin
                case (funct)
                    3'b000:  dec_op = 4'b0010;
                    3'b001:  dec_op = 4'b0000;
                    3'b010:  dec_op = 4'b0110;
                    3'b011:  dec_op = 4'b0001;
                    3'b100:  dec_op = 4'b1001;
                    3'b101:  dec_op = 4'b1010;
                    3'b110:  dec_op = 4'b0111;
                    default: dec_op = 4'b1111;
                endcase
            end
            4'b0001: begin
                case (funct)
                    3'b000: begin
                        dec_op  = 4'b1000;
                        dec_mul = 1'b1;
                    end
                    3'b001: begin
                        dec_op   = 4'b1111;
                        dec_hilo = 2'b01;
                    end
                    3'b010: begin
                        dec_op   = 4'b1111;
                        dec_hilo = 2'b10;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            4'b0010: dec_op = 4'b0010;
            4'b0011: dec_op = 4'b0000;
            4'b0100: dec_op = 4'b0001;
            4'b0101: begin
                dec_op  = 4'b1000;
                dec_mul = 1'b1;
            end
            4'b0110: dec_op = 4'b0110;
            4'b0111: dec_op = 4'b0110;
            4'b1000: dec_op = 4'b0111;
            4'b1001: dec_op = 4'b0010;
            4'b1010: dec_op = 4'b0010;
            4'b1011: dec_op = 4'b1111;
            4'b1100: dec_op = 4'b1111;
            4'b1101: begin
                case (funct)
                    3'b000:  dec_op = 4'b1100;
                    3'b001:  dec_op = 4'b0011;
                    3'b010:  dec_op = 4'b1101;
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase
    end

`ifdef MULDIV_SIGNED_EN
    // Signed build: iterate on magnitudes, remember whether to negate.
    always_comb begin
        a_mag  = src_a[DATA_W-1] ? (~src_a + 1'b1) : src_a;
        b_mag  = src_b[DATA_W-1] ? (~src_b + 1'b1) : src_b;
        neg_in = src_a[DATA_W-1] ^ src_b[DATA_W-1];
    end
`else
    // Unsigned build: operands go straight into the iteration.
    always_comb begin
        a_mag  = src_a;
        b_mag  = src_b;
        neg_in = 1'b0;
    end
`endif

    // One shift-add step: conditionally add the multiplicand into the upper
    // half (carry kept), then shift the whole accumulator right by one.
    always_comb begin
        upper_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]}
                  + {1'b0, (acc_q[0] ? mcand_q : {DATA_W{1'b0}})};
        acc_step  = {upper_sum, acc_q[DATA_W-1:1]};
        product   = neg_q ? (~acc_step + 1'b1) : acc_step;
    end

    // Next-state, decode capture and multiplier datapath control.
    always_comb begin
        state_d        = state_q;
        alu_op_d       = alu_op_q;
        alu_op_valid_d = accept;
        illegal_d      = illegal_q;
        hilo_sel_d     = hilo_sel_q;
        mcand_d        = mcand_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        neg_d          = neg_q;
        hi_d           = hi_q;
        lo_d           = lo_q;

        if (accept) begin
            alu_op_d   = dec_op;
            illegal_d  = dec_ill;
            hilo_sel_d = dec_hilo;
        end

        case (state_q)
            IDLE, DONE: begin
                if (accept && dec_mul) begin
                    state_d = MUL;
                    mcand_d = a_mag;
                    acc_d   = {{DATA_W{1'b0}}, b_mag};
                    cnt_d   = '0;
                    neg_d   = neg_in;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            MUL: begin
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    hi_d    = product[2*DATA_W-1:DATA_W];
                    lo_d    = product[DATA_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            alu_op_q       <= 4'b0000;
            alu_op_valid_q <= 1'b0;
            illegal_q      <= 1'b0;
            hilo_sel_q     <= 2'b00;
            mcand_q        <= '0;
            acc_q          <= '0;
            cnt_q          <= '0;
            neg_q          <= 1'b0;
            hi_q           <= '0;
            lo_q           <= '0;
        end else begin
            state_q        <= state_d;
            alu_op_q       <= alu_op_d;
            alu_op_valid_q <= alu_op_valid_d;
            illegal_q      <= illegal_d;
            hilo_sel_q     <= hilo_sel_d;
            mcand_q        <= mcand_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            neg_q          <= neg_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
        end
    end

    assign alu_op       = alu_op_q;
    assign alu_op_valid = alu_op_valid_q;
    assign illegal      = illegal_q;
    assign hilo_sel     = hilo_sel_q;
    assign stall        = (state_q == MUL);
    assign mul_done     = (state_q == DONE);
    assign hi           = hi_q;
    assign lo           = lo_q;

endmodule
